// File: rtl/mem_port_arbiter_pkg.sv
// Arbiter-local types: who owns the in-flight read and the two-state access FSM.
package ArbType;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DM   = 2'd2
  } owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

endpackage : ArbType

// File: rtl/types_pkg.sv
// Shared address and data word types used across the pipeline and memory path.
package Types;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] op_t;
  typedef logic [31:0] inst_t;

endpackage : Types

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (read-only) and the data path.
// One access at a time; reads wait out a fixed latency, writes complete in one cycle.
module mem_port_arbiter
  import Types::*;
  import ArbType::*;
#(
  parameter int READ_LATENCY  = 2,
  parameter int MAX_DM_STREAK = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  if_req,
  input  addr_t if_addr,
  output logic  if_gnt,
  output logic  if_rvalid,
  output inst_t if_rdata,
  input  logic  dm_req,
  input  logic  dm_we,
  input  addr_t dm_addr,
  input  op_t   dm_wdata,
  output logic  dm_gnt,
  output logic  dm_rvalid,
  output op_t   dm_rdata,
  output logic  dm_wdone,
  output logic  mem_en,
  output logic  mem_we,
  output addr_t mem_addr,
  output op_t   mem_wdata,
  input  op_t   mem_rdata
);

  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic          dm_wdone_q, dm_wdone_d;
  inst_t         if_rdata_q, if_rdata_d;
  op_t           dm_rdata_q, dm_rdata_d;

  logic          streak_at_max;
  logic          if_wins;
  logic          dm_wins;

  // IF only beats DM once the data path has taken its quota of grants over a waiting fetch.
  assign streak_at_max = (streak_q == SW'(MAX_DM_STREAK));
  assign if_wins       = if_req && (!dm_req || streak_at_max);
  assign dm_wins       = dm_req && !if_wins;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    streak_d    = streak_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    dm_wdone_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      ARB_IDLE: begin
        // Grants are suppressed while reset is held so every output stays quiet.
        if (!rst) begin
          if (if_wins) begin
            if_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            owner_d   = OWNER_IF;
            lat_cnt_d = LW'(READ_LATENCY);
            state_d   = ARB_WAIT;
            streak_d  = '0;
          end else if (dm_wins) begin
            dm_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_we   = dm_we;
            mem_addr = dm_addr;
            if (dm_we) begin
              mem_wdata  = dm_wdata;
              dm_wdone_d = 1'b1;
            end else begin
              owner_d   = OWNER_DM;
              lat_cnt_d = LW'(READ_LATENCY);
              state_d   = ARB_WAIT;
            end
            if (!if_req) begin
              streak_d = '0;
            end else if (!streak_at_max) begin
              streak_d = streak_q + SW'(1);
            end
          end else begin
            streak_d = '0;
          end
        end
      end

      ARB_WAIT: begin
        lat_cnt_d = lat_cnt_q - LW'(1);
        // Last wait cycle: the macro output is valid now, so capture it for the owner.
        if (lat_cnt_q == LW'(1)) begin
          state_d = ARB_IDLE;
          owner_d = OWNER_NONE;
          if (owner_q == OWNER_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else if (owner_q == OWNER_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata;
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_NONE;
      lat_cnt_q   <= '0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_wdone_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_wdone_q  <= dm_wdone_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_wdone  = dm_wdone_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural fixed-latency memory macro.
module tb_mem_port_arbiter;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_wdone;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [6:0] obs;
  assign obs = {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, dm_wdone};

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LATENCY(RL), .MAX_DM_STREAK(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_wdone(dm_wdone),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory macro: word array plus an RL-deep read pipeline; preloaded while rst is high.
  logic [31:0] mem_arr [256];
  logic [31:0] rd_pipe [RL];
  assign mem_rdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= {24'hA50000, i[7:0]};
      mem_arr[16] <= 32'h2002_0005;
      mem_arr[17] <= 32'h3333_4444;
      mem_arr[18] <= 32'h5555_6666;
      mem_arr[64] <= 32'h1111_2222;
    end else if (mem_en && mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
    rd_pipe[0] <= mem_arr[mem_addr[9:2]];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h40; dm_addr = 32'h100; dm_wdata = 32'h0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== 7'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs flags=%b addr=%h wdata=%h want 0", obs, mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata if=%h dm=%h want 0", if_rdata, dm_rdata);
    end
    $display("reset: flags=%b", obs);
    if_req = 1'b0; dm_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle flags=%b want 0000000", obs);
    end
    next_cycle();
  endtask

  task automatic test_if_read();
    logic [6:0] exp_v [4] = '{7'b1010000, 7'b0, 7'b0, 7'b0000100};
    if_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      if_req = (c == 0);
      @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++;
        $display("FAIL if_read c%0d flags=%b want %b", c, obs, exp_v[c]);
      end
      $display("if_read c%0d: flags=%b addr=%h rdata=%h", c, obs, mem_addr, if_rdata);
      if (c == 0) begin
        checks++;
        if (mem_addr !== 32'h40) begin
          errors++;
          $display("FAIL if_read_addr got %h want 00000040", mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (if_rdata !== 32'h2002_0005) begin
          errors++;
          $display("FAIL if_read_data got %h want 20020005", if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_dm_priority();
    logic [6:0] exp_v [7] = '{7'b0110000, 7'b0, 7'b0, 7'b1010010, 7'b0, 7'b0, 7'b0000100};
    if_addr = 32'h44; dm_addr = 32'h100; dm_we = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if_req = (c <= 3);
      dm_req = (c == 0);
      @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++;
        $display("FAIL dm_priority c%0d flags=%b want %b", c, obs, exp_v[c]);
      end
      $display("dm_priority c%0d: flags=%b addr=%h", c, obs, mem_addr);
      if (c == 3) begin
        checks++;
        if (dm_rdata !== 32'h1111_2222 || mem_addr !== 32'h44) begin
          errors++;
          $display("FAIL dm_priority_data dm_rdata=%h addr=%h want 11112222/00000044", dm_rdata, mem_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (if_rdata !== 32'h3333_4444) begin
          errors++;
          $display("FAIL dm_priority_ifdata got %h want 33334444", if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_then_fetch();
    logic [6:0] exp_v [5] = '{7'b0111000, 7'b1010001, 7'b0, 7'b0, 7'b0000100};
    dm_addr = 32'h104; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; if_addr = 32'h104;
    for (int c = 0; c < 5; c++) begin
      dm_req = (c == 0);
      if_req = (c <= 1);
      @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++;
        $display("FAIL write c%0d flags=%b want %b", c, obs, exp_v[c]);
      end
      $display("write c%0d: flags=%b addr=%h wdata=%h", c, obs, mem_addr, mem_wdata);
      if (c == 0) begin
        checks++;
        if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h104) begin
          errors++;
          $display("FAIL write_bus wdata=%h addr=%h want deadbeef/00000104", mem_wdata, mem_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (if_rdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL write_readback got %h want deadbeef", if_rdata);
        end
      end
      next_cycle();
    end
    dm_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_v [9] = '{7'b0111000, 7'b0111001, 7'b0111001, 7'b1010001, 7'b0,
                              7'b0, 7'b0111100, 7'b0111001, 7'b0000001};
    int n = 0;
    bit if_done = 1'b0;
    if_addr = 32'h48; dm_we = 1'b1;
    for (int c = 0; c < 9; c++) begin
      dm_req = (n < 5);
      dm_addr = 32'h200 + 32'(4 * n);
      dm_wdata = 32'(n);
      if_req = !if_done;
      @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++;
        $display("FAIL back_to_back c%0d flags=%b want %b", c, obs, exp_v[c]);
      end
      $display("back_to_back c%0d: flags=%b addr=%h", c, obs, mem_addr);
      if (c == 6) begin
        checks++;
        if (if_rdata !== 32'h5555_6666) begin
          errors++;
          $display("FAIL back_to_back_ifdata got %h want 55556666", if_rdata);
        end
      end
      if (dm_gnt) n++;
      if (if_gnt) if_done = 1'b1;
      next_cycle();
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL back_to_back_count got %0d want 5", n);
    end
    dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [6:0] exp_v [7] = '{7'b0110000, 7'b0, 7'b0, 7'b1010000, 7'b0, 7'b0, 7'b0000100};
    dm_addr = 32'h100; dm_we = 1'b0; if_addr = 32'h40;
    for (int c = 0; c < 7; c++) begin
      dm_req = (c == 0);
      rst = (c == 1 || c == 2);
      if_req = (c == 2 || c == 3);
      @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++;
        $display("FAIL rst_wait c%0d flags=%b want %b", c, obs, exp_v[c]);
      end
      $display("rst_wait c%0d: flags=%b", c, obs);
      if (c == 2) begin
        checks++;
        if (dm_rdata !== 32'h0 || if_rdata !== 32'h0 || mem_addr !== 32'h0) begin
          errors++;
          $display("FAIL rst_wait_clear dm=%h if=%h addr=%h want 0", dm_rdata, if_rdata, mem_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (if_rdata !== 32'h2002_0005) begin
          errors++;
          $display("FAIL rst_wait_ifdata got %h want 20020005", if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_if_drop();
    logic [6:0] exp_v [6] = '{7'b0110000, 7'b0, 7'b0, 7'b0000010, 7'b0, 7'b0};
    dm_addr = 32'h100; dm_we = 1'b0; if_addr = 32'h44;
    for (int c = 0; c < 6; c++) begin
      dm_req = (c == 0);
      if_req = (c == 1);
      @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++;
        $display("FAIL if_drop c%0d flags=%b want %b", c, obs, exp_v[c]);
      end
      $display("if_drop c%0d: flags=%b", c, obs);
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_priority();
    test_write_then_fetch();
    test_back_to_back();
    test_reset_in_wait();
    test_if_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
